echo_line_capture: RTL and testbench
====================================

ECHO_LINE_CAPTURE -- requirements
Module: echo_line_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning ADC sample width in bits.
REQ-002 SHALL have parameter DECIM, default 4, meaning ADC samples averaged per output sample; power of two, 1..16.
REQ-003 SHALL have parameter MAX_SAMPLES, default 512, meaning maximum output samples per line.
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port Line_Num  input  8  current line index from the command generator.
REQ-007 SHALL have port Focus_Num  input  2  current focus index from the command generator.
REQ-008 SHALL have port Pr_Gate  input  1  line-prepare gate; its rising edge arms a capture.
REQ-009 SHALL have port Sample_Gate  input  1  echo sampling window, active high.
REQ-010 SHALL have port End_Gate  input  1  end-of-frame or abort, active high.
REQ-011 SHALL have port adc_data  input  DATA_W  unsigned ADC sample.
REQ-012 SHALL have port adc_valid  input  1  adc_data qualifier.
REQ-013 SHALL have port out_data  output  DATA_W  averaged sample.
REQ-014 SHALL have port out_valid  output  1  one-cycle qualifier for out_data.
REQ-015 SHALL have port out_first  output  1  high with out_valid on the first sample of a line.
REQ-016 SHALL have port line_id  output  8  Line_Num latched at arm.
REQ-017 SHALL have port focus_id  output  2  Focus_Num latched at arm.
REQ-018 SHALL have port sample_cnt  output  10  output samples emitted in the current/last line.
REQ-019 SHALL have port line_done  output  1  one-cycle pulse at line completion.
REQ-020 SHALL have port overrun_err  output  1  sticky error flag.

Function
REQ-021 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-022 SHALL detect the Pr_Gate rising edge from a registered previous value (reset value 0).
REQ-023 In IDLE, SHALL on a Pr_Gate rise latch line_id/focus_id, clear sample_cnt and the decimation accumulator, and go to ARMED.
REQ-024 In ARMED, SHALL go to CAPTURE when Sample_Gate=1; End_Gate=1 takes priority and goes to DONE.
REQ-025 In CAPTURE, SHALL accumulate adc_data on each adc_valid into a DATA_W+log2(DECIM)-bit accumulator, with a 0..DECIM-1 group counter.
REQ-026 On the DECIM-th valid of a group, SHALL register out_data = (accumulator + adc_data) >> log2(DECIM), truncated, assert out_valid the next cycle, increment sample_cnt, and restart the group.
REQ-027 SHALL ignore adc_valid outside CAPTURE and while Sample_Gate=0.
REQ-028 In CAPTURE, SHALL go to DONE when Sample_Gate falls, End_Gate=1, or sample_cnt reaches MAX_SAMPLES; any partial group SHALL be discarded.
REQ-029 When a completing group and a termination condition occur in the same cycle, SHALL emit the sample and then enter DONE.
REQ-030 DONE SHALL last one cycle, assert line_done, hold sample_cnt, and return to IDLE.
REQ-031 A Pr_Gate rise in ARMED or CAPTURE SHALL set overrun_err and SHALL NOT re-latch or restart.
REQ-032 A Pr_Gate rise in DONE SHALL be latched and SHALL arm immediately on the entry to IDLE.
REQ-033 line_id, focus_id and sample_cnt SHALL hold between lines until the next arm.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, clear all counters and the accumulator, set all outputs to 0 including overrun_err, and drop any partial line.
REQ-035 overrun_err SHALL be cleared only by reset.

Verification
REQ-036 Defaults: Pr_Gate rise with Line_Num=37 and Focus_Num=2; Sample_Gate high for 2048 consecutive valids of value 100 -> 512 samples of 100, out_first on the first only, capture stops at MAX_SAMPLES, line_done once, line_id=37, focus_id=2, sample_cnt=512.
REQ-037 Valids of 1,2,3,6 -> one out_data=3 ((12)>>2), registered one cycle after the fourth valid.
REQ-038 Sample_Gate falls after 10 valids -> 2 samples, partial group dropped, sample_cnt=2, line_done.
REQ-039 Pr_Gate re-rises mid-CAPTURE -> overrun_err=1 and sticky, line_id unchanged, capture continues.
REQ-040 reset_n low mid-CAPTURE for 1 cycle -> outputs 0, IDLE, and no line_done; a following Pr_Gate rise arms normally.
REQ-041 End_Gate=1 in ARMED -> DONE with sample_cnt=0 and no out_valid.

Source files
------------

// File: rtl/echo_line_capture.sv
// Captures one echo line per Pr_Gate rise: averages DECIM ADC samples per output and tags the line.
// Latency: out_valid is registered one cycle after the completing adc_valid. No backpressure; the source free-runs.
module echo_line_capture #(
    parameter int DATA_W      = 10,
    parameter int DECIM       = 4,
    parameter int MAX_SAMPLES = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        Line_Num,
    input  logic [1:0]        Focus_Num,
    input  logic              Pr_Gate,
    input  logic              Sample_Gate,
    input  logic              End_Gate,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic [7:0]        line_id,
    output logic [1:0]        focus_id,
    output logic [9:0]        sample_cnt,
    output logic              line_done,
    output logic              overrun_err
);
    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = DATA_W + LOG_D;
    localparam int GRP_W = (DECIM > 1) ? LOG_D : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(DECIM - 1);
    localparam logic [9:0]       MAX_CNT  = 10'(MAX_SAMPLES);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic              pr_prev_q;
    logic              pend_q, pend_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic [7:0]        line_id_q, line_id_d;
    logic [1:0]        focus_id_q, focus_id_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              line_done_q, line_done_d;
    logic              overrun_q, overrun_d;

    logic              pr_rise;
    logic              take;
    logic [ACC_W-1:0]  sum;

    always_comb begin
        pr_rise     = Pr_Gate & ~pr_prev_q;
        take        = (state_q == CAPTURE) && Sample_Gate && adc_valid;
        sum         = acc_q + ACC_W'(adc_data);

        state_d     = state_q;
        pend_d      = pend_q;
        acc_d       = acc_q;
        grp_d       = grp_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        line_id_d   = line_id_q;
        focus_id_d  = focus_id_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                // A rise seen during DONE is honoured here, one cycle late.
                if (pr_rise || pend_q) begin
                    line_id_d  = Line_Num;
                    focus_id_d = Focus_Num;
                    cnt_d      = '0;
                    acc_d      = '0;
                    grp_d      = '0;
                    pend_d     = 1'b0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (pr_rise)
                    overrun_d = 1'b1;
                if (End_Gate)
                    state_d = DONE;
                else if (Sample_Gate)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (pr_rise)
                    overrun_d = 1'b1;
                if (take) begin
                    if (grp_q == GRP_LAST) begin
                        out_data_d  = DATA_W'(sum >> LOG_D);
                        out_valid_d = 1'b1;
                        out_first_d = (cnt_q == 10'd0);
                        cnt_d       = cnt_q + 10'd1;
                        acc_d       = '0;
                        grp_d       = '0;
                    end else begin
                        acc_d = sum;
                        grp_d = grp_q + 1'b1;
                    end
                end
                // Termination uses the post-increment count so a completing group is still emitted.
                if (!Sample_Gate || End_Gate || (cnt_d == MAX_CNT)) begin
                    state_d = DONE;
                    acc_d   = '0;
                    grp_d   = '0;
                end
            end
            DONE: begin
                if (pr_rise)
                    pend_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        line_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pr_prev_q   <= 1'b0;
            pend_q      <= 1'b0;
            acc_q       <= '0;
            grp_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            line_id_q   <= '0;
            focus_id_q  <= '0;
            cnt_q       <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pr_prev_q   <= Pr_Gate;
            pend_q      <= pend_d;
            acc_q       <= acc_d;
            grp_q       <= grp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            line_id_q   <= line_id_d;
            focus_id_q  <= focus_id_d;
            cnt_q       <= cnt_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_first   = out_first_q;
    assign line_id     = line_id_q;
    assign focus_id    = focus_id_q;
    assign sample_cnt  = cnt_q;
    assign line_done   = line_done_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_echo_line_capture.sv
// Directed and randomized line captures checked against an array-based averaging model.
module tb_echo_line_capture;
    localparam int DW   = 10;
    localparam int DEC  = 4;
    localparam int MAXS = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    Line_Num;
    logic [1:0]    Focus_Num;
    logic          Pr_Gate, Sample_Gate, End_Gate, adc_valid;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] out_data;
    logic          out_valid, out_first, line_done, overrun_err;
    logic [7:0]    line_id;
    logic [1:0]    focus_id;
    logic [9:0]    sample_cnt;

    echo_line_capture #(.DATA_W(DW), .DECIM(DEC), .MAX_SAMPLES(MAXS)) dut (
        .clk(clk), .reset_n(reset_n), .Line_Num(Line_Num), .Focus_Num(Focus_Num),
        .Pr_Gate(Pr_Gate), .Sample_Gate(Sample_Gate), .End_Gate(End_Gate),
        .adc_data(adc_data), .adc_valid(adc_valid), .out_data(out_data),
        .out_valid(out_valid), .out_first(out_first), .line_id(line_id),
        .focus_id(focus_id), .sample_cnt(sample_cnt), .line_done(line_done),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int out_q[$];
    int first_q[$];
    int ld_cnt = 0;
    int vals[$];
    int base_o, base_ld;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_q.push_back(int'(out_data));
            first_q.push_back(int'(out_first));
        end
        if (line_done === 1'b1)
            ld_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        vals.delete();
        base_o  = out_q.size();
        base_ld = ld_cnt;
    endtask

    // Arms a line and moves it into capture with no valids on the transition cycle.
    task automatic arm(int ln, int fn);
        Pr_Gate = 1'b0;
        step();
        Line_Num  = ln[7:0];
        Focus_Num = fn[1:0];
        Pr_Gate   = 1'b1;
        step();
        Pr_Gate     = 1'b0;
        Sample_Gate = 1'b1;
        step();
    endtask

    task automatic send(int v, bit with_end);
        adc_valid = 1'b1;
        adc_data  = v[DW-1:0];
        End_Gate  = with_end;
        vals.push_back(v);
        step();
        adc_valid = 1'b0;
        End_Gate  = 1'b0;
    endtask

    task automatic finish_fall();
        Sample_Gate = 1'b0;
        adc_valid   = 1'b0;
        step();
        step();
        step();
    endtask

    // Expected outputs: mean of each complete group of DEC valids, at most MAXS groups.
    task automatic verify_line(string tag, int ln, int fn);
        int ngrp;
        int e;
        ngrp = vals.size() / DEC;
        if (ngrp > MAXS)
            ngrp = MAXS;
        chk({tag, "_nsamp"}, out_q.size() - base_o, ngrp);
        for (int g = 0; g < ngrp; g++) begin
            e = 0;
            for (int k = 0; k < DEC; k++)
                e += vals[g*DEC + k];
            e = e / DEC;
            if (base_o + g < out_q.size()) begin
                chk({tag, "_data"}, out_q[base_o + g], e);
                chk({tag, "_first"}, first_q[base_o + g], (g == 0) ? 1 : 0);
            end
        end
        chk({tag, "_sample_cnt"}, sample_cnt, ngrp);
        chk({tag, "_line_done"}, ld_cnt - base_ld, 1);
        chk({tag, "_line_id"}, line_id, ln);
        chk({tag, "_focus_id"}, focus_id, fn);
    endtask

    initial begin
        reset_n = 1'b0; Line_Num = '0; Focus_Num = '0; Pr_Gate = 1'b0;
        Sample_Gate = 1'b0; End_Gate = 1'b0; adc_valid = 1'b0; adc_data = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_line_id", line_id, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_overrun", overrun_err, 0);
        step();
        reset_n = 1'b1;
        step();

        // Four valids 1,2,3,6 average to 3, visible the cycle after the fourth valid.
        mark();
        arm(5, 1);
        send(1, 0); send(2, 0); send(3, 0);
        chk("avg_pre_valid", out_valid, 0);
        send(6, 0);
        chk("avg_valid", out_valid, 1);
        chk("avg_data", out_data, 3);
        chk("avg_first", out_first, 1);
        finish_fall();
        verify_line("avg", 5, 1);

        // Default long line stops itself at MAX_SAMPLES.
        mark();
        arm(37, 2);
        for (int i = 0; i < 4 * MAXS; i++)
            send(100, 0);
        finish_fall();
        verify_line("maxline", 37, 2);

        // Gate falls after 10 valids: partial group dropped.
        mark();
        arm(8, 3);
        for (int i = 0; i < 10; i++)
            send($urandom_range(0, 1023), 0);
        finish_fall();
        verify_line("partial", 8, 3);

        // End_Gate together with a completing valid still emits that sample.
        mark();
        arm(14, 0);
        for (int i = 0; i < 8; i++)
            send($urandom_range(0, 1023), i == 7);
        finish_fall();
        verify_line("end_cmp", 14, 0);

        // End_Gate in ARMED wins over Sample_Gate.
        mark();
        Pr_Gate = 1'b0; step();
        Line_Num = 8'd50; Focus_Num = 2'd1; Pr_Gate = 1'b1; step();
        Pr_Gate = 1'b0; End_Gate = 1'b1; Sample_Gate = 1'b1; adc_valid = 1'b1; adc_data = 10'd999;
        step();
        End_Gate = 1'b0; Sample_Gate = 1'b0; adc_valid = 1'b0;
        step(); step();
        verify_line("end_armed", 50, 1);

        for (int l = 0; l < 6; l++) begin
            int n, ln, fn;
            bit em;
            n  = $urandom_range(0, 40);
            ln = $urandom_range(0, 255);
            fn = $urandom_range(0, 3);
            em = ($urandom_range(0, 1) == 1) && (n > 0);
            mark();
            arm(ln, fn);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    step();
                send($urandom_range(0, 1023), em && (i == n - 1));
            end
            finish_fall();
            verify_line("rand", ln, fn);
        end
        chk("no_overrun_yet", overrun_err, 0);

        // Pr_Gate rise mid-capture flags overrun without re-latching.
        mark();
        arm(9, 1);
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, 1023), 0);
        Line_Num = 8'd99;
        Pr_Gate  = 1'b1;
        step();
        Pr_Gate = 1'b0;
        chk("ovr_set", overrun_err, 1);
        chk("ovr_line_id", line_id, 9);
        for (int i = 0; i < 7; i++)
            send($urandom_range(0, 1023), 0);
        finish_fall();
        verify_line("ovr", 9, 1);

        // Pr_Gate rise during DONE arms on the following IDLE cycle.
        mark();
        arm(20, 0);
        for (int i = 0; i < 4; i++)
            send($urandom_range(0, 1023), 0);
        Sample_Gate = 1'b0;
        step();
        chk("pend_cnt_first", sample_cnt, 1);
        Line_Num = 8'd77; Focus_Num = 2'd3; Pr_Gate = 1'b1;
        step();
        chk("pend_done_first", ld_cnt - base_ld, 1);
        step();
        chk("pend_line_id", line_id, 77);
        chk("pend_focus_id", focus_id, 3);
        chk("pend_cnt_clear", sample_cnt, 0);
        Sample_Gate = 1'b1;
        step();
        mark();
        for (int i = 0; i < 4; i++)
            send($urandom_range(0, 1023), 0);
        finish_fall();
        Pr_Gate = 1'b0;
        verify_line("pend", 77, 3);
        chk("ovr_sticky", overrun_err, 1);

        // One-cycle reset mid-capture clears everything and produces no line_done.
        mark();
        arm(12, 1);
        for (int i = 0; i < 6; i++)
            send($urandom_range(1, 1023), 0);
        reset_n = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_data", out_data, 0);
        chk("rst2_sample_cnt", sample_cnt, 0);
        chk("rst2_line_id", line_id, 0);
        chk("rst2_focus_id", focus_id, 0);
        chk("rst2_overrun", overrun_err, 0);
        Sample_Gate = 1'b0;
        step();
        reset_n = 1'b1;
        step(); step();
        chk("rst2_no_done", ld_cnt - base_ld, 0);
        mark();
        arm(13, 3);
        for (int i = 0; i < 4; i++)
            send($urandom_range(0, 1023), 0);
        finish_fall();
        verify_line("post_rst", 13, 3);
        chk("post_rst_overrun", overrun_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
